// File: rtl/led_score_latch.sv
// ---------------------------------------------------------------------------
// led_score_latch
//   Latches one reaction-time score per round, in BCD, onto the LED bank and
//   holds it there. Keeps track of the best (lowest) valid score seen. On a
//   false start it blinks the two status LEDs until the round is disarmed.
//
// Ports
//   cin         clock, rising edge
//   rst_n       asynchronous reset, active low
//   arm         round active; when low, returns to IDLE and blanks the LEDs
//   capture     1-cycle pulse: digits carries the measured reaction time
//   early       1-cycle pulse: false start
//   clr_best    1-cycle pulse: forget the best score
//   digits      packed BCD score, digit 0 in the LSBs
//   light       LED bank: {error/fault, new_best, digits}
//   held        high while a score is held
//   best        best valid score (0 when best_valid is low)
//   best_valid  best holds a real score
// ---------------------------------------------------------------------------
module led_score_latch #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                              cin,
    input  logic                              rst_n,
    input  logic                              arm,
    input  logic                              capture,
    input  logic                              early,
    input  logic                              clr_best,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]     digits,
    output logic [NUM_DIGITS*DIGIT_W+1:0]     light,
    output logic                              held,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     best,
    output logic                              best_valid
);

    localparam int unsigned DATA_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned LED_W  = DATA_W + 2;
    localparam int unsigned CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HELD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LED_W-1:0]    light_q, light_d;
    logic                held_q, held_d;
    logic [DATA_W-1:0]   best_q, best_d;
    logic                best_valid_q, best_valid_d;
    logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;

    logic                digits_ok_c;
    logic                beats_best_c;

    // A capture is only a real score when every digit is a legal BCD value.
    always_comb begin
        digits_ok_c = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (32'(digits[i*DIGIT_W +: DIGIT_W]) > 32'd9) begin
                digits_ok_c = 1'b0;
            end
        end
    end

    // A same-cycle clr_best empties the record, so the capture always wins it.
    assign beats_best_c = !best_valid_q || clr_best || (digits < best_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        light_d      = light_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        blink_cnt_d  = blink_cnt_q;
        held_d       = 1'b0;

        if (clr_best) begin
            best_d       = '0;
            best_valid_d = 1'b0;
        end

        if (!arm) begin
            state_d     = S_IDLE;
            light_d     = '0;
            blink_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                    light_d = '0;
                end

                S_ARMED: begin
                    if (early) begin
                        state_d     = S_FAULT;
                        light_d     = {2'b11, DATA_W'(0)};
                        blink_cnt_d = '0;
                    end else if (capture) begin
                        state_d = S_HELD;
                        if (!digits_ok_c) begin
                            light_d = {2'b10, digits};
                        end else if (beats_best_c) begin
                            light_d      = {2'b01, digits};
                            best_d       = digits;
                            best_valid_d = 1'b1;
                        end else begin
                            light_d = {2'b00, digits};
                        end
                    end
                end

                S_HELD: begin
                    // One latch per round: hold until disarmed.
                    state_d = S_HELD;
                end

                S_FAULT: begin
                    // Status pair toggles together once per BLINK_DIV cycles.
                    if (blink_cnt_q == CNT_LAST) begin
                        blink_cnt_d = '0;
                        light_d     = {~light_q[LED_W-1:LED_W-2], DATA_W'(0)};
                    end else begin
                        blink_cnt_d = blink_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    light_d = '0;
                end
            endcase
        end

        held_d = (state_d == S_HELD);
    end

    // State and output registers.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            light_q      <= '0;
            held_q       <= 1'b0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            light_q      <= light_d;
            held_q       <= held_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign light      = light_q;
    assign held       = held_q;
    assign best       = best_q;
    assign best_valid = best_valid_q;

endmodule

// File: tb/tb_led_score_latch.sv
// ---------------------------------------------------------------------------
// tb_led_score_latch
//   Directed stimulus with hand-computed expectations, plus a per-cycle
//   comparison against a round-level behavioural model of the latch.
// ---------------------------------------------------------------------------
module tb_led_score_latch;

    localparam int unsigned ND    = 2;
    localparam int unsigned DW    = 4;
    localparam int unsigned BLINK = 4;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_HELD  = 2;
    localparam int P_FAULT = 3;

    logic        cin;
    logic        rst_n;
    logic        arm;
    logic        capture;
    logic        early;
    logic        clr_best;
    logic [7:0]  digits;
    logic [9:0]  light;
    logic        held;
    logic [7:0]  best;
    logic        best_valid;

    int tests_run;
    int tests_failed;

    // Model of what the LED bank and score record must show.
    int          m_phase;
    int          m_age;
    logic [9:0]  m_light;
    logic [7:0]  m_best;
    logic        m_bv;

    led_score_latch #(
        .NUM_DIGITS (ND),
        .DIGIT_W    (DW),
        .BLINK_DIV  (BLINK)
    ) dut (
        .cin        (cin),
        .rst_n      (rst_n),
        .arm        (arm),
        .capture    (capture),
        .early      (early),
        .clr_best   (clr_best),
        .digits     (digits),
        .light      (light),
        .held       (held),
        .best       (best),
        .best_valid (best_valid)
    );

    initial begin
        cin = 1'b0;
        forever #5 cin = ~cin;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every decimal digit of the packed value must be 0..9.
    function automatic bit bcd_ok(input logic [7:0] v);
        int x;
        x = int'(v);
        for (int i = 0; i < int'(ND); i++) begin
            if (((x / (16 ** i)) % 16) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_age   = 0;
            m_light = '0;
            m_best  = '0;
            m_bv    = 1'b0;
            return;
        end
        if (clr_best) begin
            m_best = '0;
            m_bv   = 1'b0;
        end
        if (!arm) begin
            m_phase = P_IDLE;
            m_light = '0;
        end else begin
            case (m_phase)
                P_IDLE:  m_phase = P_ARMED;
                P_ARMED: begin
                    if (early) begin
                        m_phase = P_FAULT;
                        m_age   = 0;
                    end else if (capture) begin
                        m_phase = P_HELD;
                        if (!bcd_ok(digits)) begin
                            m_light = {2'b10, digits};
                        end else if (!m_bv || digits < m_best) begin
                            m_best  = digits;
                            m_bv    = 1'b1;
                            m_light = {2'b01, digits};
                        end else begin
                            m_light = {2'b00, digits};
                        end
                    end
                end
                P_FAULT: m_age++;
                default: ;
            endcase
        end
        if (m_phase == P_FAULT) begin
            m_light = (((m_age / int'(BLINK)) % 2) == 0) ? 10'h300 : 10'h000;
        end
    endtask

    // Advance the model on each edge and compare shortly after it.
    always @(posedge cin) begin
        model_step();
        #1;
        check("cyc_light", 64'(light), 64'(m_light));
        check("cyc_held", 64'(held), 64'(m_phase == P_HELD));
        check("cyc_best", 64'(best), 64'(m_best));
        check("cyc_best_valid", 64'(best_valid), 64'(m_bv));
    end

    task automatic step(input logic a, input logic c, input logic e, input logic clr,
                        input logic [7:0] d);
        arm      = a;
        capture  = c;
        early    = e;
        clr_best = clr;
        digits   = d;
        @(negedge cin);
        capture  = 1'b0;
        early    = 1'b0;
        clr_best = 1'b0;
    endtask

    task automatic new_round();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cap(input logic [7:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_phase = P_IDLE;
        m_age   = 0;
        m_light = '0;
        m_best  = '0;
        m_bv    = 1'b0;
        rst_n    = 1'b0;
        arm      = 1'b0;
        capture  = 1'b0;
        early    = 1'b0;
        clr_best = 1'b0;
        digits   = 8'h00;

        repeat (2) @(negedge cin);
        check("rst_light", 64'(light), 64'h0);
        check("rst_held", 64'(held), 64'h0);
        check("rst_best", 64'(best), 64'h0);
        check("rst_best_valid", 64'(best_valid), 64'h0);
        rst_n = 1'b1;

        // First round: first score is automatically a new best.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cap(8'h37);
        check("cap37_light", 64'(light), 64'h137);
        check("cap37_held", 64'(held), 64'h1);
        check("cap37_best", 64'(best), 64'h37);
        check("cap37_bv", 64'(best_valid), 64'h1);

        // Second capture in the same round is ignored.
        cap(8'h12);
        check("relatch_light", 64'(light), 64'h137);
        check("relatch_best", 64'(best), 64'h37);

        // Disarm blanks LEDs but keeps the record.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("disarm_light", 64'(light), 64'h000);
        check("disarm_best", 64'(best), 64'h37);

        new_round();
        cap(8'h52);
        check("slow_light", 64'(light), 64'h052);
        check("slow_best", 64'(best), 64'h37);

        new_round();
        cap(8'h21);
        check("better_light", 64'(light), 64'h121);
        check("better_best", 64'(best), 64'h21);

        new_round();
        cap(8'h21);
        check("equal_light", 64'(light), 64'h021);

        // False start with a coincident capture: fault blink, 4 on / 4 off.
        new_round();
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 12; i++) begin
            check("fault_light", 64'(light), (((i / 4) % 2) == 0) ? 64'h300 : 64'h000);
            check("fault_held", 64'(held), 64'h0);
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
        end
        check("fault_best", 64'(best), 64'h21);

        // Invalid capture shows raw digits with the error bit.
        new_round();
        cap(8'h3A);
        check("inv_light", 64'(light), 64'h23A);
        check("inv_held", 64'(held), 64'h1);
        check("inv_best", 64'(best), 64'h21);

        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_bv", 64'(best_valid), 64'h0);
        check("clr_best", 64'(best), 64'h00);
        check("clr_light", 64'(light), 64'h23A);

        new_round();
        cap(8'hA0);
        check("inv_hi_light", 64'(light), 64'h2A0);
        check("inv_hi_bv", 64'(best_valid), 64'h0);

        new_round();
        cap(8'h45);
        check("after_clr_light", 64'(light), 64'h145);
        check("after_clr_best", 64'(best), 64'h45);

        new_round();
        cap(8'h00);
        check("zero_light", 64'(light), 64'h100);
        check("zero_held", 64'(held), 64'h1);
        check("zero_best", 64'(best), 64'h00);

        // clr_best together with a valid capture: the capture wins.
        new_round();
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
        check("clrcap_light", 64'(light), 64'h199);
        check("clrcap_best", 64'(best), 64'h99);
        check("clrcap_bv", 64'(best_valid), 64'h1);

        // Disarm overrides a same-cycle capture.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
        check("arm0cap_light", 64'(light), 64'h000);
        check("arm0cap_best", 64'(best), 64'h99);

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cap(8'h77);
        check("pre_rst_light", 64'(light), 64'h177);

        // Asynchronous reset mid-cycle while holding.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_light", 64'(light), 64'h000);
        check("async_held", 64'(held), 64'h0);
        check("async_bv", 64'(best_valid), 64'h0);
        check("async_best", 64'(best), 64'h00);

        repeat (3) @(negedge cin);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cap(8'h88);
        check("post_rst_light", 64'(light), 64'h188);
        check("post_rst_best", 64'(best), 64'h88);

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge cin);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
